// File: rtl/decode_pkg.sv
// Shared decode types: control bundle, RV32I opcodes, ALU/memory/RF-source codes
// and the immediate/ALU-selection helpers used by the field decoder.
package decode_pkg;

  localparam int CTRL_XLEN  = 32;
  localparam int CTRL_REG_W = 5;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W} mem_size_t;

  typedef enum logic [1:0] {RF_SRC_ALU, RF_SRC_MEM, RF_SRC_PC4} rf_src_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    alu_op_t                alu_op;
    logic                   src_a_pc;
    logic                   src_b_imm;
    logic                   rs1_used;
    logic                   rs2_used;
    logic                   mem_rd;
    logic                   mem_wr;
    mem_size_t              mem_size;
    logic                   mem_unsigned;
    logic                   rf_wr_en;
    rf_src_t                rf_src;
    logic                   branch;
    logic                   jump;
    logic [2:0]             br_cond;
    logic [CTRL_REG_W-1:0]  rs1;
    logic [CTRL_REG_W-1:0]  rs2;
    logic [CTRL_REG_W-1:0]  rd;
    logic [CTRL_XLEN-1:0]   imm;
  } ctrl_t;

  function automatic logic [CTRL_XLEN-1:0] imm_of(input logic [31:0] i, input imm_fmt_t f);
    case (f)
      IMM_I:   imm_of = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm_of = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm_of = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   imm_of = {i[31:12], 12'b0};
      IMM_J:   imm_of = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: imm_of = '0;
    endcase
  endfunction

  // alt selects SUB/SRA (funct7[5]); compares map onto ALU ops, never RF strobes
  function automatic alu_op_t alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Pure combinational RV32I decoder: instruction word -> control bundle + illegal flag.
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0] instruction,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  always_comb begin
    ctrl         = '0;
    illegal      = 1'b0;
    ctrl.alu_op  = ALU_ADD;
    ctrl.mem_size = MEM_W;
    ctrl.rf_src  = RF_SRC_ALU;
    ctrl.rs1     = instruction[19:15];
    ctrl.rs2     = instruction[24:20];
    ctrl.rd      = instruction[11:7];
    case (opcode)
      OPC_LUI: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.alu_op    = ALU_PASS_B;
        ctrl.imm       = imm_of(instruction, IMM_U);
      end
      OPC_AUIPC: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.src_a_pc  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.imm       = imm_of(instruction, IMM_U);
      end
      OPC_JAL: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.src_a_pc  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.rf_src    = RF_SRC_PC4;
        ctrl.imm       = imm_of(instruction, IMM_J);
      end
      OPC_JALR: begin
        illegal        = (f3 != 3'b000);
        ctrl.rf_wr_en  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.rs1_used  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.rf_src    = RF_SRC_PC4;
        ctrl.imm       = imm_of(instruction, IMM_I);
      end
      OPC_BRANCH: begin
        illegal       = (f3[2:1] == 2'b01);
        ctrl.branch   = 1'b1;
        ctrl.rs1_used = 1'b1;
        ctrl.rs2_used = 1'b1;
        ctrl.br_cond  = f3;
        ctrl.alu_op   = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        ctrl.imm      = imm_of(instruction, IMM_B);
      end
      OPC_LOAD: begin
        illegal           = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        ctrl.rf_wr_en     = 1'b1;
        ctrl.mem_rd       = 1'b1;
        ctrl.rs1_used     = 1'b1;
        ctrl.src_b_imm    = 1'b1;
        ctrl.rf_src       = RF_SRC_MEM;
        ctrl.mem_size     = mem_size_t'(f3[1:0]);
        ctrl.mem_unsigned = f3[2];
        ctrl.imm          = imm_of(instruction, IMM_I);
      end
      OPC_STORE: begin
        illegal        = f3[2] || (f3[1:0] == 2'b11);
        ctrl.mem_wr    = 1'b1;
        ctrl.rs1_used  = 1'b1;
        ctrl.rs2_used  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.mem_size  = mem_size_t'(f3[1:0]);
        ctrl.imm       = imm_of(instruction, IMM_S);
      end
      OPC_OP_IMM: begin
        illegal        = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                         ((f3 == 3'b101) && ((f7 & 7'b1011111) != 7'h00));
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rs1_used  = 1'b1;
        ctrl.src_b_imm = 1'b1;
        ctrl.alu_op    = alu_of(f3, (f3 == 3'b101) && f7[5]);
        ctrl.imm       = imm_of(instruction, IMM_I);
      end
      OPC_OP: begin
        illegal       = !((f7 == 7'h00) ||
                          ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
        ctrl.rf_wr_en = 1'b1;
        ctrl.rs1_used = 1'b1;
        ctrl.rs2_used = 1'b1;
        ctrl.alu_op   = alu_of(f3, f7[5]);
      end
      OPC_MISC_MEM, OPC_SYSTEM: ;  // fence/ecall/ebreak travel as no-ops
      default: illegal = 1'b1;
    endcase
    // illegal bundles must never write state or claim register operands
    if (illegal) begin
      ctrl.rf_wr_en = 1'b0;
      ctrl.mem_wr   = 1'b0;
      ctrl.mem_rd   = 1'b0;
      ctrl.rs1_used = 1'b0;
      ctrl.rs2_used = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.jump     = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipe stage: combinational field decode, one output register with
// valid/ready handshake, and a pending-write scoreboard for RAW/WAW interlock.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_W    = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instruction,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output ctrl_t            out_ctrl,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             flush
);

  ctrl_t                dec;
  logic                 dec_illegal;
  logic                 started;
  logic                 hazard;
  logic                 accept;
  logic [NUM_REGS-1:0]  pending;
  logic [NUM_REGS-1:0]  pending_n;
  logic [REG_W-1:0]     dec_rs1, dec_rs2, dec_rd, held_rd;

  decode_fields u_fields (
    .instruction (in_instruction),
    .ctrl        (dec),
    .illegal     (dec_illegal)
  );

  assign dec_rs1 = dec.rs1[REG_W-1:0];
  assign dec_rs2 = dec.rs2[REG_W-1:0];
  assign dec_rd  = dec.rd[REG_W-1:0];
  assign held_rd = out_ctrl.rd[REG_W-1:0];

  // hazard looks only at the registered scoreboard, so a same-cycle writeback
  // releases the interlock one cycle later
  assign hazard = in_valid && ((dec.rs1_used && pending[dec_rs1]) ||
                               (dec.rs2_used && pending[dec_rs2]) ||
                               (dec.rf_wr_en && pending[dec_rd]));

  assign in_ready = started && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) started <= 1'b0;
    else       started <= 1'b1;
  end

  // order matters: clears first, then a new set wins over a same-index clear
  always_comb begin
    pending_n = pending;
    if (wb_valid) pending_n[wb_rd] = 1'b0;
    if (flush && out_valid && out_ctrl.rf_wr_en) pending_n[held_rd] = 1'b0;
    if (accept && dec.rf_wr_en) pending_n[dec_rd] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_n;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_ctrl    <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_ctrl    <= dec;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, scoreboard interlock, flush,
// immediate formats, illegal opcodes and asynchronous reset.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  ctrl_t       out_ctrl;
  logic        out_illegal;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_ADD2  = 32'h0010_8133;  // add  x2,x1,x1
  localparam logic [31:0] I_ADDI3 = 32'h0070_0193;  // addi x3,x0,7
  localparam logic [31:0] I_ADDI4 = 32'h0010_0213;  // addi x4,x0,1
  localparam logic [31:0] I_ADDI5 = 32'h0090_0293;  // addi x5,x0,9

  decode_stage dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instruction (in_instruction),
    .in_pc          (in_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_ctrl       (out_ctrl),
    .out_illegal    (out_illegal),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .flush          (flush)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instruction = inst;
    in_pc = pc;
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_pc !== 32'h0 || out_ctrl !== '0 || out_illegal !== 1'b0) begin errors++; $display("FAIL reset_outputs: pc %h ctrl %h ill %b want zeros", out_pc, out_ctrl, out_illegal); end
    checks++; if (dut.pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h want 0", dut.pending); end
    tick;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready: got %b want 0", in_ready); end
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_edge_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi;
    out_ready = 1'b1;
    offer(I_ADDI1, 32'h100);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_ready: got %b want 1", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL addi_out: valid %b pc %h want 1 100", out_valid, out_pc); end
    checks++; if (out_ctrl.imm !== 32'd5 || out_ctrl.rd !== 5'd1 || out_ctrl.alu_op !== ALU_ADD || out_ctrl.rf_wr_en !== 1'b1) begin errors++; $display("FAIL addi_ctrl: imm %h rd %0d alu %0d wr %b want 5 1 ADD 1", out_ctrl.imm, out_ctrl.rd, out_ctrl.alu_op, out_ctrl.rf_wr_en); end
    checks++; if (dut.pending[1] !== 1'b1) begin errors++; $display("FAIL addi_pending1: got %b want 1", dut.pending[1]); end
  endtask

  task automatic test_raw;
    offer(I_ADD2, 32'h104);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_blocked: got %b want 0", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL raw_held: valid %b ready %b want 0 0", out_valid, in_ready); end
    wb_valid = 1'b1; wb_rd = 5'd1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_same_cycle: got %b want 0", in_ready); end
    tick;
    wb_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || dut.pending[1] !== 1'b0) begin errors++; $display("FAIL raw_released: ready %b pend1 %b want 1 0", in_ready, dut.pending[1]); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || out_ctrl.rd !== 5'd2 || out_ctrl.rs1 !== 5'd1) begin errors++; $display("FAIL raw_accept: valid %b pc %h rd %0d rs1 %0d want 1 104 2 1", out_valid, out_pc, out_ctrl.rd, out_ctrl.rs1); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    offer(I_ADDI3, 32'h108);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: ready %b valid %b want 0 1", i, in_ready, out_valid); end
      checks++; if (out_pc !== 32'h104 || out_ctrl.rd !== 5'd2 || out_ctrl.rs2 !== 5'd1 || out_ctrl.alu_op !== ALU_ADD) begin errors++; $display("FAIL stall_stable%0d: pc %h rd %0d rs2 %0d alu %0d want 104 2 1 ADD", i, out_pc, out_ctrl.rd, out_ctrl.rs2, out_ctrl.alu_op); end
      tick;
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release: valid %b want 0", out_valid); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    offer(I_ADDI3, 32'h10C);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_pre_accept: got %b want 1", in_ready); end
    tick;
    checks++; if (out_valid !== 1'b1 || dut.pending[3] !== 1'b1) begin errors++; $display("FAIL flush_held: valid %b pend3 %b want 1 1", out_valid, dut.pending[3]); end
    flush = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd2;
    offer(I_ADDI5, 32'h110);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks: got %b want 0", in_ready); end
    tick;
    flush = 1'b0; wb_valid = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    checks++; if (dut.pending !== 32'h0) begin errors++; $display("FAIL flush_pending: got %h want 0", dut.pending); end
  endtask

  task automatic test_flush_idle;
    flush = 1'b1;
    offer(I_ADDI5, 32'h114);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b want 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || dut.pending !== 32'h0) begin errors++; $display("FAIL flush_idle_state: valid %b pend %h want 0 0", out_valid, dut.pending); end
  endtask

  task automatic test_same_edge;
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd4;
    offer(I_ADDI4, 32'h200);
    tick;
    wb_valid = 1'b0; in_valid = 1'b0;
    checks++; if (dut.pending[4] !== 1'b1) begin errors++; $display("FAIL same_edge_pend4: got %b want 1", dut.pending[4]); end
    checks++; if (out_valid !== 1'b1 || out_ctrl.rd !== 5'd4 || out_ctrl.imm !== 32'd1) begin errors++; $display("FAIL same_edge_out: valid %b rd %0d imm %h want 1 4 1", out_valid, out_ctrl.rd, out_ctrl.imm); end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic        wr;
    logic        mw;
    logic        ill;
    alu_op_t     alu;
  } vec_t;

  task automatic test_back_to_back;
    vec_t v[5];
    v[0] = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, ALU_SUB};    // beq x0,x0,-4
    v[1] = '{32'h0000_007F, 32'h0000_0000, 1'b0, 1'b0, 1'b1, ALU_ADD};    // unknown opcode
    v[2] = '{32'hFE11_2C23, 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, ALU_ADD};    // sw x1,-8(x2)
    v[3] = '{32'h8000_0337, 32'h8000_0000, 1'b1, 1'b0, 1'b0, ALU_PASS_B}; // lui x6,0x80000
    v[4] = '{32'h0020_A3B3, 32'h0000_0000, 1'b1, 1'b0, 1'b0, ALU_SLT};    // slt x7,x1,x2
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(v[i].inst, 32'h300 + 32'(i * 4));
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready: got %b want 1", i, in_ready); end
      tick;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300 + 32'(i * 4) || out_illegal !== v[i].ill) begin errors++; $display("FAIL b2b%0d_out: valid %b pc %h ill %b want 1 %h %b", i, out_valid, out_pc, out_illegal, 32'h300 + 32'(i * 4), v[i].ill); end
      checks++; if (out_ctrl.imm !== v[i].imm || out_ctrl.rf_wr_en !== v[i].wr || out_ctrl.mem_wr !== v[i].mw || out_ctrl.alu_op !== v[i].alu) begin errors++; $display("FAIL b2b%0d_ctrl: imm %h wr %b mw %b alu %0d want %h %b %b %0d", i, out_ctrl.imm, out_ctrl.rf_wr_en, out_ctrl.mem_wr, out_ctrl.alu_op, v[i].imm, v[i].wr, v[i].mw, v[i].alu); end
    end
    in_valid = 1'b0;
    checks++; if (dut.pending !== 32'h0000_00D0) begin errors++; $display("FAIL b2b_pending: got %h want 000000d0", dut.pending); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    offer(I_ADDI5, 32'h400);
    tick;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dut.pending[5] !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: valid %b pend5 %b want 1 1", out_valid, dut.pending[5]); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || dut.pending !== 32'h0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid: valid %b pend %h ready %b want 0 0 0", out_valid, dut.pending, in_ready); end
    @(negedge clock);
    reset = 1'b0;
    tick;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_recover: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_raw;
    test_stall;
    test_flush;
    test_flush_idle;
    test_same_edge;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Params (name, default, meaning) SHALL be: XLEN, 32, datapath/immediate width; NUM_REGS, 32, architectural registers (power of 2); REG_W, $clog2(NUM_REGS), register index width.
REQ-002 Ports (name, direction, width, meaning) SHALL be, clock and reset first:
  clock  in  1  sole clock, rising edge;
  reset  in  1  asynchronous, active-high;
  in_valid  in  1  fetch presents instruction;
  in_ready  out  1  stage accepts this cycle;
  in_instruction  in  32  RV32I encoding;
  in_pc  in  XLEN  instruction address;
  out_valid  out  1  registered bundle valid;
  out_ready  in  1  execute accepts bundle;
  out_pc  out  XLEN  registered pc;
  out_ctrl  out  ctrl_t  registered control bundle (ALU op, mux selects, mem size/sign/wr, rf_wr_en, rs1, rs2, rd, immediate);
  out_illegal  out  1  unknown opcode/funct;
  wb_valid  in  1  writeback retiring;
  wb_rd  in  REG_W  register being retired;
  flush  in  1  discard held bundle (branch/jump redirect).
REQ-003 Clocking: one clock; reset is asynchronous and active-high.

Function
REQ-004 Decode SHALL be combinational in sub-module decode_fields, output registered once: latency one cycle from accept to out_valid.
REQ-005 Handshake SHALL be valid/ready: in transfer when in_valid&&in_ready; out transfer when out_valid&&out_ready; out_pc/out_ctrl stable while out_valid&&!out_ready.
REQ-006 in_ready SHALL equal !flush && !hazard && (!out_valid || out_ready) (full-throughput skid-free pipe register).
REQ-007 Scoreboard SHALL hold NUM_REGS pending bits; bit 0 hardwired 0.
REQ-008 hazard SHALL be 1 when in_valid and pending[rs1] (if used), pending[rs2] (if used), or pending[rd] (if written, WAW), using registered scoreboard only.
REQ-009 On accept with rf_wr_en && rd!=0, pending[rd] SHALL set at that edge.
REQ-010 On wb_valid, pending[wb_rd] SHALL clear at that edge; clear visible to hazard next cycle.
REQ-011 Simultaneous set and clear of the same index SHALL leave the bit set.
REQ-012 flush SHALL clear out_valid at the edge and clear pending[rd] of the discarded bundle when it set one; a concurrent wb_valid clear is also applied.
REQ-013 flush with out_valid=0 SHALL change nothing except blocking accept that cycle.
REQ-014 Immediate SHALL be sign-extended to XLEN per I/S/B/U/J format; U-type {imm[31:12],12'b0} sign-extended above bit 31.
REQ-015 Unknown opcode SHALL be accepted with out_illegal=1, rf_wr_en=0, mem_wr=0, no scoreboard set.
REQ-016 SLT/SLTU/SLTI/SLTIU SHALL decode to ALU compare ops (no RF set/reset strobes).

Reset
REQ-017 While reset: out_valid=0, out_illegal=0, out_pc=0, out_ctrl=0, scoreboard all 0; in_ready=0 until first edge after deassertion.
REQ-018 Reset mid-operation SHALL drop held bundle and all pending bits without waiting for writeback.

Structure
REQ-019 Shared package decode_pkg SHALL hold ctrl_t, opcode constants, ALU op codes, memory size codes, RF data-source codes.
REQ-020 One sub-module decode_fields (pure combinational instruction -> ctrl_t, illegal) SHALL be instantiated; scoreboard and pipe register stay in decode_stage.

Verification
REQ-021 addi x1,x0,5 accepted, out_ready=1 -> next cycle out_valid=1, imm=5, rd=1, ALU ADD; pending[1]=1.
REQ-022 add x2,x1,x1 following, no wb -> in_ready=0 held; wb_valid,wb_rd=1 -> in_ready=1 next cycle, accept.
REQ-023 out_ready=0 for 3 cycles with bundle held -> out_ctrl/out_pc unchanged, in_ready=0; release -> one transfer.
REQ-024 flush on held addi x3 -> out_valid=0 next cycle, pending[3]=0; instruction offered same cycle not accepted.
REQ-025 wb_valid rd=4 same edge as accepting addi x4 -> pending[4]=1; beq imm -4 -> imm 0xFFFFFFFC; opcode 7'h7F -> out_illegal=1.
REQ-026 reset asserted with out_valid=1, pending[5]=1 -> immediately out_valid=0, scoreboard 0.
